// File: rtl/aes128_decipher_core_if.sv
// Host-side bus of the iterative AES-128 decipher core: start handshake,
// ciphertext input, round-key write port and plaintext result.
interface aes128_decipher_core_if;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned IDX_W   = 4;

    logic               next;
    logic [BLOCK_W-1:0] block;
    logic               key_wr_en;
    logic [IDX_W-1:0]   key_wr_idx;
    logic [BLOCK_W-1:0] key_wr_data;
    logic               ready;
    logic [BLOCK_W-1:0] result;
    logic               result_valid;

    modport master (
        output next, block, key_wr_en, key_wr_idx, key_wr_data,
        input  ready, result, result_valid
    );

    modport slave (
        input  next, block, key_wr_en, key_wr_idx, key_wr_data,
        output ready, result, result_valid
    );
endinterface

// File: rtl/aes128_decipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock, with an 11-entry
// round-key memory written by the host while the core is idle.

// Inverse S-box: inverse affine transform followed by GF(2^8) inversion (x^254).
module aes_inv_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] pre;
    assign pre = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    assign y   = gf_inv(pre);
endmodule

module aes128_decipher_core #(
    parameter int unsigned AES128_ROUNDS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    aes128_decipher_core_if.slave    bus
);
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t               fsm_state;
    logic [ROUND_W-1:0] round;
    logic [BLOCK_W-1:0] state_reg;
    logic [BLOCK_W-1:0] result_reg;
    logic               ready_reg;
    logic               valid_reg;
    logic [BLOCK_W-1:0] key_mem [0:AES128_ROUNDS];

    logic [BLOCK_W-1:0] isr;
    logic [BLOCK_W-1:0] isb;
    logic [BLOCK_W-1:0] ark;
    logic [BLOCK_W-1:0] imc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant coefficient multiply assembled from an xtime chain.
    function automatic logic [7:0] mul_coef(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Byte n sits at bits [127-8n -: 8]; state is column-major, byte n = row + 4*col.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0]         a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = mul_coef(a[r], 4'he) ^ mul_coef(a[(r+1)%4], 4'hb) ^
                                        mul_coef(a[(r+2)%4], 4'hd) ^ mul_coef(a[(r+3)%4], 4'h9);
            end
        end
        return o;
    endfunction

    assign isr = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .x (isr[127-8*i -: 8]),
            .y (isb[127-8*i -: 8])
        );
    end

    assign ark = isb ^ key_mem[round];
    assign imc = inv_mix_columns(ark);

    // Key memory is not reset; writes only land while idle and not starting.
    always_ff @(posedge clk) begin
        if (rst && ready_reg && bus.key_wr_en && !bus.next &&
            bus.key_wr_idx <= IDX_W'(AES128_ROUNDS)) begin
            key_mem[bus.key_wr_idx] <= bus.key_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_state  <= IDLE;
            ready_reg  <= 1'b1;
            valid_reg  <= 1'b0;
            result_reg <= '0;
            round      <= '0;
            state_reg  <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (bus.next) begin
                        state_reg <= bus.block ^ key_mem[AES128_ROUNDS];
                        round     <= ROUND_W'(AES128_ROUNDS - 1);
                        ready_reg <= 1'b0;
                        fsm_state <= RUN;
                    end
                end
                RUN: begin
                    if (round != '0) begin
                        state_reg <= imc;
                        round     <= round - ROUND_W'(1);
                    end else begin
                        result_reg <= ark;
                        valid_reg  <= 1'b1;
                        ready_reg  <= 1'b1;
                        fsm_state  <= IDLE;
                    end
                end
                default: begin
                    fsm_state <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready        = ready_reg;
    assign bus.result       = result_reg;
    assign bus.result_valid = valid_reg;
endmodule

// File: tb/tb_aes128_decipher_core.sv
// Self-checking bench for aes128_decipher_core against a byte-level software
// AES inverse cipher with S-boxes derived from the GF(2^8) definition.
module tb_aes128_decipher_core;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    aes128_decipher_core_if bus ();

    aes128_decipher_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int           LAT    = 10;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] ref_rk   [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Forward S-box from its definition, then inverted as a lookup table.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) ref_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        logic [127:0] k;
        v = ct ^ ref_rk[10];
        for (int n = 0; n < 16; n++) s[n] = v[127-8*n -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            k = ref_rk[rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = inv_sbox[s[r+4*((c-r+4)%4)]];
            for (int n = 0; n < 16; n++) t[n] = t[n] ^ k[127-8*n -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[r+4*c] = gmul(8'h0e, t[4*c+r]) ^ gmul(8'h0b, t[4*c+(r+1)%4]) ^
                                   gmul(8'h0d, t[4*c+(r+2)%4]) ^ gmul(8'h09, t[4*c+(r+3)%4]);
            end else begin
                s = t;
            end
        end
        for (int n = 0; n < 16; n++) v[127-8*n -: 8] = s[n];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys();
        for (int i = 0; i < 11; i++) begin
            bus.key_wr_en   = 1'b1;
            bus.key_wr_idx  = 4'(i);
            bus.key_wr_data = ref_rk[i];
            step();
        end
        bus.key_wr_en = 1'b0;
    endtask

    // Waits gap cycles, issues one block and returns in the result_valid cycle.
    task automatic do_decrypt(input logic [127:0] ct, input int gap,
                              output logic [127:0] res, output int edges);
        repeat (gap) step();
        bus.next  = 1'b1;
        bus.block = ct;
        step();
        bus.next  = 1'b0;
        edges = -1;
        res   = 'x;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.result_valid) begin
                edges = i;
                res   = bus.result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.ready);
        end
        tests_run++;
        if (bus.result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.result_valid);
        end
        tests_run++;
        if (bus.result !== 128'h0) begin
            tests_failed++; $display("FAIL reset_result: got %h want 0", bus.result);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_fips_c1();
        logic [127:0] res;
        int           edges;
        expand_key(C1_KEY);
        load_keys();
        do_decrypt(C1_CT, 1, res, edges);
        tests_run++;
        if (edges !== LAT) begin
            tests_failed++; $display("FAIL c1_latency: got %0d want %0d", edges, LAT);
        end
        tests_run++;
        if (res !== C1_PT) begin
            tests_failed++; $display("FAIL c1_result: got %h want %h", res, C1_PT);
        end
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++; $display("FAIL c1_ready_at_valid: got %b want 1", bus.ready);
        end
        step();
        tests_run++;
        if (bus.result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL c1_valid_pulse: got %b want 0", bus.result_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        int           edges;
        bit           held;
        expand_key(B_KEY);
        load_keys();
        do_decrypt(B_CT, 0, res, edges);
        tests_run++;
        if (edges !== LAT || res !== B_PT) begin
            tests_failed++; $display("FAIL b2b_first: got %h after %0d want %h after %0d", res, edges, B_PT, LAT);
        end
        bus.next  = 1'b1;
        bus.block = B_CT;
        step();
        bus.next  = 1'b0;
        held  = 1'b1;
        edges = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.result_valid) begin
                edges = i;
                break;
            end
            if (bus.result !== B_PT) held = 1'b0;
        end
        tests_run++;
        if (!held) begin
            tests_failed++; $display("FAIL b2b_hold: got changing result want %h held", B_PT);
        end
        tests_run++;
        if (edges !== LAT || bus.result !== B_PT) begin
            tests_failed++; $display("FAIL b2b_second: got %h after %0d want %h after %0d", bus.result, edges, B_PT, LAT);
        end
    endtask

    task automatic test_busy_protection();
        logic [127:0] res;
        logic [127:0] ct;
        int           edges;
        bit           spurious;
        expand_key(C1_KEY);
        load_keys();
        bus.next  = 1'b1;
        bus.block = C1_CT;
        step();
        bus.next = 1'b0;
        repeat (3) step();
        bus.next        = 1'b1;
        bus.block       = {$urandom, $urandom, $urandom, $urandom};
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = 4'd5;
        bus.key_wr_data = 128'h0;
        step();
        step();
        bus.next      = 1'b0;
        bus.key_wr_en = 1'b0;
        edges = -1;
        for (int i = 6; i <= 30; i++) begin
            step();
            if (bus.result_valid) begin
                edges = i;
                break;
            end
        end
        tests_run++;
        if (edges !== LAT || bus.result !== C1_PT) begin
            tests_failed++; $display("FAIL busy_c1: got %h after %0d want %h after %0d", bus.result, edges, C1_PT, LAT);
        end
        spurious = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.result_valid !== 1'b0 || bus.ready !== 1'b1) spurious = 1'b1;
        end
        tests_run++;
        if (spurious) begin
            tests_failed++; $display("FAIL busy_queued: got extra activity want idle");
        end
        ct = {$urandom, $urandom, $urandom, $urandom};
        do_decrypt(ct, 0, res, edges);
        tests_run++;
        if (edges !== LAT || res !== ref_decrypt(ct)) begin
            tests_failed++; $display("FAIL busy_keys_intact: got %h want %h", res, ref_decrypt(ct));
        end
    endtask

    task automatic test_key_gating();
        logic [127:0] res;
        logic [127:0] ct;
        int           edges;
        for (int i = 11; i < 16; i++) begin
            bus.key_wr_en   = 1'b1;
            bus.key_wr_idx  = 4'(i);
            bus.key_wr_data = 128'h0;
            step();
        end
        bus.key_wr_idx = 4'd10;
        bus.next       = 1'b1;
        bus.block      = C1_CT;
        step();
        bus.next      = 1'b0;
        bus.key_wr_en = 1'b0;
        edges = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.result_valid) begin
                edges = i;
                break;
            end
        end
        tests_run++;
        if (edges !== LAT || bus.result !== C1_PT) begin
            tests_failed++; $display("FAIL gate_c1: got %h after %0d want %h", bus.result, edges, C1_PT);
        end
        ct = {$urandom, $urandom, $urandom, $urandom};
        do_decrypt(ct, 2, res, edges);
        tests_run++;
        if (edges !== LAT || res !== ref_decrypt(ct)) begin
            tests_failed++; $display("FAIL gate_keys_intact: got %h want %h", res, ref_decrypt(ct));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] res;
        int           edges;
        bit           pulse;
        bus.next  = 1'b1;
        bus.block = C1_CT;
        step();
        bus.next = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        step();
        tests_run++;
        if (bus.ready !== 1'b1 || bus.result !== 128'h0 || bus.result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got ready=%b valid=%b result=%h want 1 0 0",
                     bus.ready, bus.result_valid, bus.result);
        end
        rst   = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.result_valid !== 1'b0) pulse = 1'b1;
        end
        tests_run++;
        if (pulse) begin
            tests_failed++; $display("FAIL midrun_no_pulse: got result_valid pulse want none");
        end
        do_decrypt(C1_CT, 0, res, edges);
        tests_run++;
        if (edges !== LAT || res !== C1_PT) begin
            tests_failed++; $display("FAIL midrun_rerun: got %h after %0d want %h", res, edges, C1_PT);
        end
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] exp;
        logic [127:0] res;
        int           edges;
        for (int k = 0; k < 25; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            load_keys();
            for (int b = 0; b < 8; b++) begin
                ct  = {$urandom, $urandom, $urandom, $urandom};
                exp = ref_decrypt(ct);
                do_decrypt(ct, int'($urandom_range(0, 5)), res, edges);
                tests_run++;
                if (edges !== LAT || res !== exp) begin
                    tests_failed++;
                    $display("FAIL random_%0d_%0d: got %h after %0d want %h after %0d",
                             k, b, res, edges, exp, LAT);
                end
            end
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b0;
        bus.next        = 1'b0;
        bus.block       = '0;
        bus.key_wr_en   = 1'b0;
        bus.key_wr_idx  = '0;
        bus.key_wr_data = '0;
        build_tables();
        test_reset();
        test_fips_c1();
        test_back_to_back();
        test_busy_protection();
        test_key_gating();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
